// File: rtl/i2c_cfg_seq_if.sv
// Request/response channel between the configuration sequencer (master)
// and the byte-level I2C engine (slave).
interface i2c_cfg_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;

    modport master (
        output req_valid, req_rw, req_dev, req_reg, req_wdata,
        input  req_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata,
        output req_ready, rsp_valid, rsp_nack, rsp_rdata
    );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Table-driven I2C configuration sequencer: one register write per table entry,
// with gaps, delays, NACK retries. `CFG_READBACK_EN adds a verify-read per write.
module i2c_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR  = 7'h48,
    parameter int unsigned TBL_AW    = 5,
    parameter int unsigned GAP_CYC   = 2700,
    parameter int unsigned DLY_UNIT  = 27000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] err_idx,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [17:0]       tbl_data,
    i2c_cfg_seq_if.master     bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RSP,
        S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {OP_WR, OP_DLY, OP_NOP, OP_END} op_t;
    typedef enum logic [1:0] {TGT_NEXT, TGT_WR, TGT_RD} tgt_t;

    localparam int unsigned DLY_MAX = 255 * DLY_UNIT;
    localparam int unsigned CNT_MAX = (DLY_MAX > GAP_CYC) ? DLY_MAX : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [RTY_W-1:0]  rty_t;
    typedef logic [TBL_AW-1:0] addr_t;

    localparam cnt_t  GAP_LOAD  = cnt_t'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam rty_t  RTY_MAX   = rty_t'(MAX_RETRY);
    localparam addr_t ADDR_LAST = '1;

    state_t     state_q, state_d;
    addr_t      tbl_addr_q, tbl_addr_d;
    addr_t      err_idx_q, err_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       req_valid_q, req_valid_d;
    logic       req_rw_q, req_rw_d;
    logic [7:0] req_reg_q, req_reg_d;
    logic [7:0] req_wdata_q, req_wdata_d;
    cnt_t       cnt_q, cnt_d;
    rty_t       retry_q, retry_d;
    tgt_t       gap_tgt_q, gap_tgt_d;

    op_t        op;
    logic [7:0] ent_data;
    logic       rsp_ok;

    assign op       = op_t'(tbl_data[17:16]);
    assign ent_data = tbl_data[7:0];

`ifdef CFG_READBACK_EN
    localparam logic RB_EN = 1'b1;
    // A read attempt succeeds only if the slave returns what was written.
    assign rsp_ok = !bus.rsp_nack && (!req_rw_q || (bus.rsp_rdata == req_wdata_q));
`else
    localparam logic RB_EN = 1'b0;
    logic unused_rdata;
    assign rsp_ok       = !bus.rsp_nack;
    assign unused_rdata = ^bus.rsp_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= '0;
            err_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_rw_q    <= 1'b0;
            req_reg_q   <= '0;
            req_wdata_q <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            gap_tgt_q   <= TGT_NEXT;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            err_idx_q   <= err_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            req_rw_q    <= req_rw_d;
            req_reg_q   <= req_reg_d;
            req_wdata_q <= req_wdata_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            gap_tgt_q   <= gap_tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_WR:   state_d = S_ISSUE;
                    OP_DLY:  state_d = (ent_data == 8'd0) ? S_NEXT : S_DELAY;
                    OP_NOP:  state_d = S_NEXT;
                    default: state_d = S_DONE;
                endcase
            end
            S_ISSUE:    if (bus.req_ready) state_d = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    if (rsp_ok || (retry_q < RTY_MAX)) state_d = S_GAP;
                    else                               state_d = S_ERROR;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = (gap_tgt_q == TGT_NEXT) ? S_NEXT : S_ISSUE;
            end
            S_DELAY:    if (cnt_q == '0) state_d = S_NEXT;
            S_NEXT:     state_d = (tbl_addr_q == ADDR_LAST) ? S_DONE : S_FETCH;
            S_DONE:     state_d = S_IDLE;
            S_ERROR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tbl_addr_d  = tbl_addr_q;
        err_idx_d   = err_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        req_valid_d = req_valid_q;
        req_rw_d    = req_rw_q;
        req_reg_d   = req_reg_q;
        req_wdata_d = req_wdata_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        gap_tgt_d   = gap_tgt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tbl_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    retry_d    = '0;
                end
            end
            S_DECODE: begin
                if (op == OP_WR) begin
                    req_reg_d   = tbl_data[15:8];
                    req_wdata_d = ent_data;
                    req_rw_d    = 1'b0;
                    req_valid_d = 1'b1;
                    retry_d     = '0;
                end else if (op == OP_DLY && ent_data != 8'd0) begin
                    cnt_d = cnt_t'(ent_data) * cnt_t'(DLY_UNIT) - cnt_t'(1);
                end
            end
            S_ISSUE: begin
                if (bus.req_ready) req_valid_d = 1'b0;
            end
            S_WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    // With readback the retry budget spans the whole write+read
                    // pair, so it is only cleared once the entry fully succeeds.
                    if (rsp_ok) begin
                        cnt_d = GAP_LOAD;
                        if (RB_EN && !req_rw_q) begin
                            gap_tgt_d = TGT_RD;
                        end else begin
                            gap_tgt_d = TGT_NEXT;
                            retry_d   = '0;
                        end
                    end else if (retry_q < RTY_MAX) begin
                        cnt_d     = GAP_LOAD;
                        retry_d   = retry_q + rty_t'(1);
                        gap_tgt_d = TGT_WR;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (gap_tgt_q != TGT_NEXT) begin
                        req_valid_d = 1'b1;
                        req_rw_d    = RB_EN && (gap_tgt_q == TGT_RD);
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_DELAY: begin
                if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
            end
            S_NEXT: begin
                if (tbl_addr_q != ADDR_LAST) tbl_addr_d = tbl_addr_q + addr_t'(1);
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            S_ERROR: begin
                err_d     = 1'b1;
                err_idx_d = tbl_addr_q;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_idx       = err_idx_q;
    assign tbl_addr      = tbl_addr_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_rw    = req_rw_q;
    assign bus.req_dev   = DEV_ADDR;
    assign bus.req_reg   = req_reg_q;
    assign bus.req_wdata = req_wdata_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Scoreboard bench for i2c_cfg_seq: directed tables, behavioural I2C engine,
// monitor checks every request handshake against hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_cfg_seq;
    localparam int unsigned AW   = 5;
    localparam int unsigned GAP  = 20;
    localparam int unsigned DLYU = 10;
    localparam int unsigned MAXR = 3;
    localparam logic [6:0]  DEV  = 7'h48;
    // Handshake-to-handshake spacing: retry/read re-issue vs. advance to next entry.
    localparam int unsigned G5   = GAP + 5;
    localparam int unsigned G8   = GAP + 8;

    typedef struct packed {
        logic        rw;
        logic [7:0]  rg;
        logic [7:0]  wd;
        int unsigned sp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, err;
    logic [AW-1:0] err_idx, tbl_addr;
    logic [17:0]   tbl_data;

    i2c_cfg_seq_if bus();

    i2c_cfg_seq #(
        .DEV_ADDR (DEV),
        .TBL_AW   (AW),
        .GAP_CYC  (GAP),
        .DLY_UNIT (DLYU),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_idx (err_idx),
        .tbl_addr(tbl_addr),
        .tbl_data(tbl_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [17:0] rom [32];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t        exp_q[$];
    int unsigned prev_edge = 0;
    int unsigned stall_cnt = 0;

    int          nack_left   [256];
    int          bad_rd_left [256];
    logic [7:0]  mem         [256];
    int          hold_left = 0;
    int          rsp_lat   = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] wr(input logic [7:0] r, input logic [7:0] d);
        return {2'b00, r, d};
    endfunction
    function automatic logic [17:0] dly(input logic [7:0] n);
        return {2'b01, 8'h00, n};
    endfunction
    localparam logic [17:0] NOP  = {2'b10, 16'h0000};
    localparam logic [17:0] ENDT = {2'b11, 16'h0000};

    // ---------------- behavioural I2C engine ----------------
    initial begin
        int   timer;
        exp_t cur;
        timer = 0;
        cur   = '0;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        bus.rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (rst) begin
                timer = 0;
                bus.req_ready = 1'b1;
            end else begin
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_nack  = 1'b0;
                        bus.rsp_rdata = 8'h00;
                        if (!cur.rw) begin
                            if (nack_left[cur.rg] > 0) begin
                                nack_left[cur.rg]--;
                                bus.rsp_nack = 1'b1;
                            end else begin
                                mem[cur.rg] = cur.wd;
                            end
                        end else if (bad_rd_left[cur.rg] > 0) begin
                            bad_rd_left[cur.rg]--;
                        end else begin
                            bus.rsp_rdata = mem[cur.rg];
                        end
                    end
                end
                bus.req_ready = !(bus.req_valid && hold_left > 0);
                if (bus.req_valid && hold_left > 0) hold_left--;
                if (bus.req_valid && bus.req_ready) begin
                    cur.rw = bus.req_rw;
                    cur.rg = bus.req_reg;
                    cur.wd = bus.req_wdata;
                    timer  = rsp_lat;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [23:0] snap, curv;
    logic        snap_ok = 1'b0;
    initial begin
        exp_t        e;
        int unsigned hs_edge;
        forever begin
            @(negedge clk);
            #2;
            curv = {bus.req_rw, bus.req_dev, bus.req_reg, bus.req_wdata};
            if (rst || !bus.req_valid) begin
                snap_ok = 1'b0;
            end else begin
                if (snap_ok) chk("req_stable", {8'h00, curv}, {8'h00, snap});
                if (bus.req_ready) begin
                    hs_edge = cyc + 1;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_req: got rw %b reg 0x%h data 0x%h, required no request",
                                 bus.req_rw, bus.req_reg, bus.req_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_rw",      {31'd0, bus.req_rw}, {31'd0, e.rw});
                        chk("req_reg",     {24'd0, bus.req_reg}, {24'd0, e.rg});
                        chk("req_wdata",   {24'd0, bus.req_wdata}, {24'd0, e.wd});
                        chk("req_dev",     {25'd0, bus.req_dev}, {25'd0, DEV});
                        chk("req_spacing", hs_edge - prev_edge, e.sp);
                    end
                    prev_edge = hs_edge;
                    snap_ok   = 1'b0;
                end else begin
                    snap    = curv;
                    snap_ok = 1'b1;
                    stall_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic rw, input logic [7:0] r, input logic [7:0] d, input int unsigned sp);
        exp_t e;
        e.rw = rw; e.rg = r; e.wd = d; e.sp = sp;
        exp_q.push_back(e);
    endtask

    // An accepted write; with readback it is followed by its verifying read.
    task automatic push_wr(input logic [7:0] r, input logic [7:0] d, input int unsigned sp);
        push(1'b0, r, d, sp);
`ifdef CFG_READBACK_EN
        push(1'b1, r, d, G5);
`endif
    endtask

    task automatic fill_rom(input logic [17:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    task automatic load_basic();
        fill_rom(ENDT);
        rom[0] = wr(8'h51, 8'h00);
        rom[1] = wr(8'h65, 8'h00);
        rom[2] = wr(8'h71, 8'h08);
        rom[3] = ENDT;
    endtask

    task automatic push_basic();
        push_wr(8'h51, 8'h00, 3);
        push_wr(8'h65, 8'h00, G8);
        push_wr(8'h71, 8'h08, G8);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        prev_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic finish_run(input logic exp_done, input logic exp_err);
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("err",  {31'd0, err},  {31'd0, exp_err});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("exp_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            nack_left[i] = 0; bad_rd_left[i] = 0; mem[i] = 8'h00;
        end
        fill_rom(ENDT);

        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_done",     {31'd0, done}, 32'd0);
        chk("rst_err",      {31'd0, err},  32'd0);
        chk("rst_valid",    {31'd0, bus.req_valid}, 32'd0);
        chk("rst_rw",       {31'd0, bus.req_rw}, 32'd0);
        chk("rst_tbl_addr", {27'd0, tbl_addr}, 32'd0);
        chk("rst_err_idx",  {27'd0, err_idx}, 32'd0);
        chk("rst_dev",      {25'd0, bus.req_dev}, {25'd0, DEV});
        chk("rst_reg",      {24'd0, bus.req_reg}, 32'd0);
        chk("rst_wdata",    {24'd0, bus.req_wdata}, 32'd0);
        rst = 1'b0;

        // Basic three-write table with start-to-request latency.
        load_basic();
        push_basic();
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("valid_in_fetch", {31'd0, bus.req_valid}, 32'd0);
        @(negedge clk);
        chk("valid_in_decode", {31'd0, bus.req_valid}, 32'd0);
        @(negedge clk);
        chk("valid_in_issue", {31'd0, bus.req_valid}, 32'd1);
        wait_idle(2000);
        finish_run(1'b1, 1'b0);

        // Engine stalls the first request for 50 cycles; a start during the run is ignored.
        load_basic();
        stall_cnt = 0;
        hold_left = 50;
        push_wr(8'h51, 8'h00, 53);
        push_wr(8'h65, 8'h00, G8);
        push_wr(8'h71, 8'h08, G8);
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(2000);
        chk("stall_cycles", stall_cnt, 32'd50);
        finish_run(1'b1, 1'b0);

        // Entry 1 NACKs every attempt: 4 issues then abort at index 1.
        load_basic();
        nack_left[8'h65] = 1000;
        push_wr(8'h51, 8'h00, 3);
        push(1'b0, 8'h65, 8'h00, G8);
        push(1'b0, 8'h65, 8'h00, G5);
        push(1'b0, 8'h65, 8'h00, G5);
        push(1'b0, 8'h65, 8'h00, G5);
        pulse_start();
        wait_idle(2000);
        chk("err_idx", {27'd0, err_idx}, 32'd1);
        finish_run(1'b0, 1'b1);
        nack_left[8'h65] = 0;

        // Entry 0 NACKs once, then the run completes.
        load_basic();
        nack_left[8'h51] = 1;
        push(1'b0, 8'h51, 8'h00, 3);
        push_wr(8'h51, 8'h00, G5);
        push_wr(8'h65, 8'h00, G8);
        push_wr(8'h71, 8'h08, G8);
        pulse_start();
        wait_idle(2000);
        finish_run(1'b1, 1'b0);

        // Delay entry of 3 ticks ahead of a write.
        fill_rom(ENDT);
        rom[0] = dly(8'd3);
        rom[1] = wr(8'h10, 8'hAA);
        push_wr(8'h10, 8'hAA, 36);
        pulse_start();
        wait_idle(2000);
        finish_run(1'b1, 1'b0);

        // Reset while a request is stalled in ISSUE drops req_valid next edge.
        load_basic();
        hold_left = 1000;
        pulse_start();
        n = 0;
        while (!bus.req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_reached", {31'd0, bus.req_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_issue_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        hold_left = 0;

        // Reset while waiting for a response, then a clean run from entry 0.
        rsp_lat = 1000;
        push(1'b0, 8'h51, 8'h00, 3);
        pulse_start();
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("in_wait_rsp", {30'd0, busy, bus.req_valid}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_wait_busy",  {31'd0, busy}, 32'd0);
        chk("rst_wait_addr",  {27'd0, tbl_addr}, 32'd0);
        chk("rst_wait_reg",   {24'd0, bus.req_reg}, 32'd0);
        rst = 1'b0;
        rsp_lat = 4;
        push_basic();
        pulse_start();
        wait_idle(2000);
        finish_run(1'b1, 1'b0);

        // Table without END: stops at the last entry, no wrap.
        fill_rom(NOP);
        pulse_start();
        wait_idle(2000);
        chk("implicit_end_addr", {27'd0, tbl_addr}, 32'd31);
        finish_run(1'b1, 1'b0);

`ifdef CFG_READBACK_EN
        // Readback returns 0x00 for written 0xAA once: the write is re-issued.
        fill_rom(ENDT);
        rom[0] = wr(8'h10, 8'hAA);
        bad_rd_left[8'h10] = 1;
        push(1'b0, 8'h10, 8'hAA, 3);
        push(1'b1, 8'h10, 8'hAA, G5);
        push(1'b0, 8'h10, 8'hAA, G5);
        push(1'b1, 8'h10, 8'hAA, G5);
        pulse_start();
        wait_idle(2000);
        finish_run(1'b1, 1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
